fetch_sequencer: RTL and testbench

Instruction-fetch controller for the core's front end. Owns the program-counter register, sequences it through the PC4Adder (PC + 4) or a redirect target, and drives a single-outstanding request/grant/response handshake to instruction memory. Delivers one fetched instruction at a time, with its PC and PC + 4, to decode, holding it until decode accepts. Sits between instruction memory and the decode stage.

---
 rtl/fetch_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, runs a single-outstanding
// req/gnt/rvalid handshake to instruction memory and hands one instruction at a time to decode.

module pc4_adder (
  input  logic [31:0] i_a,
  output logic [31:0] o_sum
);
  assign o_sum = i_a + 32'd4;
endmodule

module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_discard;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_misalign;
  logic [31:0] r_fetch_count;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic        w_discard_next;
  logic        w_if_valid_next;
  logic [31:0] w_if_instr_next;
  logic [31:0] w_if_pc_next;
  logic        w_misalign_next;
  logic [31:0] w_fetch_count_next;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_if_pc_plus4;

  pc4_adder u_pc_adder (
    .i_a   (r_pc),
    .o_sum (w_pc_plus4)
  );

  pc4_adder u_if_pc_adder (
    .i_a   (r_if_pc),
    .o_sum (w_if_pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_VECTOR;
      r_discard     <= 1'b0;
      r_if_valid    <= 1'b0;
      r_if_instr    <= 32'd0;
      r_if_pc       <= RESET_VECTOR;
      r_misalign    <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_discard     <= w_discard_next;
      r_if_valid    <= w_if_valid_next;
      r_if_instr    <= w_if_instr_next;
      r_if_pc       <= w_if_pc_next;
      r_misalign    <= w_misalign_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_discard_next     = r_discard;
    w_if_valid_next    = r_if_valid;
    w_if_instr_next    = r_if_instr;
    w_if_pc_next       = r_if_pc;
    w_misalign_next    = 1'b0;
    w_fetch_count_next = r_fetch_count;

    if (redirect_valid) begin
      // Redirect wins over grant, response and consume alike.
      w_pc_next       = {redirect_target[31:2], 2'b00};
      w_if_valid_next = 1'b0;
      w_misalign_next = |redirect_target[1:0];
      case (r_state)
        ST_FETCH: begin
          if (imem_gnt) begin
            w_state_next   = ST_WAIT;
            w_discard_next = 1'b1;
          end else begin
            w_state_next = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            w_state_next   = ST_FETCH;
            w_discard_next = 1'b0;
          end else begin
            w_state_next   = ST_WAIT;
            w_discard_next = 1'b1;
          end
        end
        ST_HOLD: w_state_next = ST_FETCH;
        default: w_state_next = ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_gnt) begin
            w_state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (r_discard) begin
              w_discard_next = 1'b0;
              w_state_next   = ST_FETCH;
            end else begin
              w_if_instr_next = imem_rdata;
              w_if_pc_next    = r_pc;
              w_if_valid_next = 1'b1;
              w_state_next    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (if_ready) begin
            w_pc_next          = w_pc_plus4;
            w_if_valid_next    = 1'b0;
            w_fetch_count_next = r_fetch_count + 32'd1;
            w_state_next       = ST_FETCH;
          end
        end
        default: w_state_next = ST_FETCH;
      endcase
    end
  end

  assign imem_req     = (r_state == ST_FETCH);
  assign imem_addr    = r_pc;
  assign if_valid     = r_if_valid;
  assign if_instr     = r_if_instr;
  assign if_pc        = r_if_pc;
  assign if_pc4       = w_if_pc_plus4;
  assign misalign_err = r_misalign;
  assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: drives a small memory model and
// checks fetch order, backpressure, redirects, misalignment, wrap and reset.

module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_total = 0;
  int n_bad   = 0;

  fetch_sequencer #(.RESET_VECTOR(32'h0000_1000)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc4          (if_pc4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One full fetch starting in FETCH at address a; optionally consumed.
  task automatic fetch_one(input logic [31:0] a, input bit consume, input int gnt_delay);
    chk("req_in_fetch", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, a);
    for (int i = 0; i < gnt_delay; i++) begin
      step;
      chk("req_stall", {31'd0, imem_req}, 32'd1);
    end
    imem_gnt = 1'b1;
    step;
    imem_gnt = 1'b0;
    chk("req_in_wait", {31'd0, imem_req}, 32'd0);
    chk("valid_in_wait", {31'd0, if_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(a);
    step;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    chk("hold_valid", {31'd0, if_valid}, 32'd1);
    chk("hold_instr", if_instr, mem_word(a));
    chk("hold_pc", if_pc, a);
    chk("hold_pc4", if_pc4, a + 32'd4);
    chk("req_in_hold", {31'd0, imem_req}, 32'd0);
    if (consume) begin
      if_ready = 1'b1;
      step;
      if_ready = 1'b0;
      chk("consumed_valid", {31'd0, if_valid}, 32'd0);
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", imem_addr, a + 32'd4);
    end
  endtask

  initial begin
    reset           = 1'b1;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'd0;
    if_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    step;
    step;
    reset = 1'b0;

    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0000_1000);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0000_1000);

    // Sequential fetches, zero-wait memory
    fetch_one(32'h0000_1000, 1'b1, 0);
    fetch_one(32'h0000_1004, 1'b1, 0);
    fetch_one(32'h0000_1008, 1'b1, 0);
    chk("count_after_3", fetch_count, 32'd3);

    // Backpressure in HOLD
    fetch_one(32'h0000_100C, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("bp_valid", {31'd0, if_valid}, 32'd1);
      chk("bp_instr", if_instr, mem_word(32'h0000_100C));
      chk("bp_pc", if_pc, 32'h0000_100C);
      chk("bp_req", {31'd0, imem_req}, 32'd0);
    end
    if_ready = 1'b1;
    step;
    if_ready = 1'b0;
    chk("bp_next_addr", imem_addr, 32'h0000_1010);
    chk("bp_next_req", {31'd0, imem_req}, 32'd1);
    chk("bp_count", fetch_count, 32'd4);

    // Redirect in WAIT before rvalid; response two cycles later is dropped
    imem_gnt = 1'b1;
    step;
    imem_gnt        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_2000;
    step;
    redirect_valid = 1'b0;
    chk("rw_req", {31'd0, imem_req}, 32'd0);
    chk("rw_valid", {31'd0, if_valid}, 32'd0);
    chk("rw_misalign", {31'd0, misalign_err}, 32'd0);
    step;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h0000_1010);
    step;
    imem_rvalid = 1'b0;
    chk("rw_drop_valid", {31'd0, if_valid}, 32'd0);
    chk("rw_drop_req", {31'd0, imem_req}, 32'd1);
    chk("rw_drop_addr", imem_addr, 32'h0000_2000);
    chk("rw_drop_count", fetch_count, 32'd4);
    step;
    chk("rw_still_fetch", {31'd0, imem_req}, 32'd1);
    chk("rw_still_invalid", {31'd0, if_valid}, 32'd0);

    // Redirect in HOLD with if_ready in the same cycle
    fetch_one(32'h0000_2000, 1'b0, 0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_2800;
    if_ready        = 1'b1;
    step;
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    chk("rh_valid", {31'd0, if_valid}, 32'd0);
    chk("rh_count", fetch_count, 32'd4);
    chk("rh_req", {31'd0, imem_req}, 32'd1);
    chk("rh_addr", imem_addr, 32'h0000_2800);

    // Misaligned redirect
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_3002;
    step;
    redirect_valid = 1'b0;
    chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
    chk("mis_addr", imem_addr, 32'h0000_3000);
    chk("mis_req", {31'd0, imem_req}, 32'd1);
    step;
    chk("mis_clear", {31'd0, misalign_err}, 32'd0);

    // Redirect in WAIT coinciding with rvalid, target at the top of memory
    imem_gnt = 1'b1;
    step;
    imem_gnt        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    imem_rvalid     = 1'b1;
    imem_rdata      = mem_word(32'h0000_3000);
    step;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    chk("rr_req", {31'd0, imem_req}, 32'd1);
    chk("rr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("rr_valid", {31'd0, if_valid}, 32'd0);

    // Wrap from 0xFFFF_FFFC to 0
    fetch_one(32'hFFFF_FFFC, 1'b1, 0);
    chk("wrap_count", fetch_count, 32'd5);

    // Reset in WAIT; the late response must be ignored
    imem_gnt = 1'b1;
    step;
    imem_gnt = 1'b0;
    reset    = 1'b1;
    step;
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step;
    imem_rvalid = 1'b0;
    chk("rst2_valid", {31'd0, if_valid}, 32'd0);
    chk("rst2_req", {31'd0, imem_req}, 32'd1);
    chk("rst2_addr", imem_addr, 32'h0000_1000);
    chk("rst2_count", fetch_count, 32'd0);
    chk("rst2_if_pc", if_pc, 32'h0000_1000);
    fetch_one(32'h0000_1000, 1'b1, 0);
    chk("rst2_count_after", fetch_count, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
